// File: rtl/data_sync_tx.sv
// Source-domain launcher for a flop-synchronized bus crossing: latches a word,
// raises a level enable, and holds the bus until the enable high/low cycle completes.
module data_sync_tx #(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter bit USE_ACK     = 1'b1
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 ack,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 tx_done
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SEND    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      count;
  logic [NUM_STAGES-1:0] ack_sync;
  logic                  ack_s;
  logic                  ack_high_ok;
  logic                  ack_low_ok;

  // Handshake: a word transfers on a rising clk edge where in_valid and in_ready
  // are both high; the source holds in_valid/in_data stable until that edge, and
  // in_ready depends only on the state register and RST.
  assign in_ready = (state == IDLE) & RST;

  assign ack_s       = ack_sync[NUM_STAGES-1];
  assign ack_high_ok = !USE_ACK || ack_s;
  assign ack_low_ok  = !USE_ACK || !ack_s;

  always_ff @(posedge clk) begin
    if (!RST) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[NUM_STAGES-2:0], ack};
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state      <= IDLE;
      count      <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Data and enable launch on the same edge so data is never later than enable.
            unsync_bus <= in_data;
            bus_enable <= 1'b1;
            count      <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (count == HOLD_LAST && ack_high_ok) begin
            bus_enable <= 1'b0;
            count      <= '0;
            state      <= RELEASE;
          end else if (count != HOLD_LAST) begin
            count <= count + 1'b1;
          end
        end
        RELEASE: begin
          if (count == GAP_LAST && ack_low_ok) begin
            tx_done <= 1'b1;
            count   <= '0;
            state   <= IDLE;
          end else if (count != GAP_LAST) begin
            count <= count + 1'b1;
          end
        end
        default: begin
          bus_enable <= 1'b0;
          count      <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_sync_tx.sv
// Bench for data_sync_tx: one timed-only instance (a) and one ack-handshake instance (b),
// checked every cycle against a cycle-count model plus directed literal expectations.
module tb_data_sync_tx;

  localparam int NS   = 2;
  localparam int BW   = 8;
  localparam int HOLD = 4;
  localparam int GAP  = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // stimulus, index 0 = dut_a (USE_ACK=0), index 1 = dut_b (USE_ACK=1)
  logic [1:0]    in_valid_v;
  logic [BW-1:0] in_data_v [2];
  logic [1:0]    ack_v;

  logic          rdy_a, rdy_b, en_a, en_b, done_a, done_b;
  logic [BW-1:0] bus_a, bus_b;
  logic [1:0]    rdy_o, en_o, done_o;
  logic [BW-1:0] bus_o [2];

  assign rdy_o    = {rdy_b, rdy_a};
  assign en_o     = {en_b, en_a};
  assign done_o   = {done_b, done_a};
  assign bus_o[0] = bus_a;
  assign bus_o[1] = bus_b;

  data_sync_tx #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
                 .USE_ACK(1'b0)) dut_a (
    .clk(clk), .RST(rst), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(rdy_a), .ack(ack_v[0]), .unsync_bus(bus_a), .bus_enable(en_a), .tx_done(done_a)
  );

  data_sync_tx #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP),
                 .USE_ACK(1'b1)) dut_b (
    .clk(clk), .RST(rst), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(rdy_b), .ack(ack_v[1]), .unsync_bus(bus_b), .bus_enable(en_b), .tx_done(done_b)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on = 1'b0;
  int done_cnt [2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a transfer is "busy" from accept to completion; the enable
  // stays high for at least HOLD cycles (and until the delayed ack is high when
  // acknowledged), then low for at least GAP cycles (and until the delayed ack is low).
  logic [BW-1:0] m_bus [2];
  logic [1:0]    m_en, m_done, m_busy;
  int            m_hi [2];
  int            m_lo [2];
  logic [NS-1:0] m_hist [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        m_bus[d]  <= '0;
        m_en[d]   <= 1'b0;
        m_done[d] <= 1'b0;
        m_busy[d] <= 1'b0;
        m_hi[d]   <= 0;
        m_lo[d]   <= 0;
        m_hist[d] <= '0;
      end else begin
        m_hist[d] <= {m_hist[d][NS-2:0], ack_v[d]};
        m_done[d] <= 1'b0;
        if (!m_busy[d]) begin
          if (in_valid_v[d]) begin
            m_bus[d]  <= in_data_v[d];
            m_en[d]   <= 1'b1;
            m_hi[d]   <= 1;
            m_busy[d] <= 1'b1;
          end
        end else if (m_en[d]) begin
          if (m_hi[d] >= HOLD && (d == 0 || m_hist[d][NS-1])) begin
            m_en[d] <= 1'b0;
            m_lo[d] <= 1;
          end else begin
            m_hi[d] <= m_hi[d] + 1;
          end
        end else begin
          if (m_lo[d] >= GAP && (d == 0 || !m_hist[d][NS-1])) begin
            m_done[d] <= 1'b1;
            m_busy[d] <= 1'b0;
          end else begin
            m_lo[d] <= m_lo[d] + 1;
          end
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("dut%0d_bus", d), bus_o[d], m_bus[d]);
        check($sformatf("dut%0d_enable", d), en_o[d], m_en[d]);
        check($sformatf("dut%0d_tx_done", d), done_o[d], m_done[d]);
        check($sformatf("dut%0d_in_ready", d), rdy_o[d], !m_busy[d] && rst);
        if (done_o[d]) done_cnt[d]++;
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts posedges until tx_done is seen at a negedge; an expired budget is a failure.
  task automatic wait_done(input int d, input int limit, output int n);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      n++;
      @(negedge clk);
      if (done_o[d]) return;
    end
    check($sformatf("dut%0d_done_timeout", d), 0, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int hi_n, lo_n, n, cnt0, w;
  bit seen;
  int acc [3];
  logic [BW-1:0] words [3];

  initial begin
    rst = 1'b0;
    in_valid_v = 2'b00;
    in_data_v[0] = '0;
    in_data_v[1] = '0;
    ack_v = 2'b00;

    // 1: reset held with in_valid high
    in_valid_v = 2'b11;
    in_data_v[0] = 8'h77;
    in_data_v[1] = 8'h77;
    step(1);
    cmp_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_rdy_a", rdy_a, 0);
      check("t1_en_a", en_a, 0);
      check("t1_bus_a", bus_a, 0);
      check("t1_rdy_b", rdy_b, 0);
      step(1);
    end
    in_valid_v = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    check("t1_rdy_a_after", rdy_a, 1);
    check("t1_rdy_b_after", rdy_b, 1);

    // 2: timed transfer of 0xA5, ack toggled to show it is ignored
    step(1);
    ack_v[0] = 1'b1;
    in_data_v[0] = 8'hA5;
    in_valid_v[0] = 1'b1;
    step(1);
    in_valid_v[0] = 1'b0;
    ack_v[0] = 1'b0;
    @(negedge clk);
    check("t2_bus_first", bus_a, 8'hA5);
    hi_n = 0; lo_n = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_a) begin
        seen = 1'b1;
        break;
      end
      if (en_a) hi_n++;
      else lo_n++;
      @(negedge clk);
    end
    check("t2_done_seen", seen, 1);
    check("t2_enable_high_cycles", hi_n, 4);
    check("t2_enable_low_cycles", lo_n, 2);
    check("t2_rdy_at_done", rdy_a, 1);
    @(negedge clk);
    check("t2_done_one_cycle", done_a, 0);
    check("t2_bus_kept", bus_a, 8'hA5);

    // 3: ack handshake, ack raised 10 cycles after enable rises
    step(1);
    in_data_v[1] = 8'h3C;
    in_valid_v[1] = 1'b1;
    step(1);
    in_valid_v[1] = 1'b0;
    step(10);
    ack_v[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n++;
      @(negedge clk);
      if (!en_b) break;
    end
    check("t3_enable_fall_latency", n, NS + 1);
    check("t3_bus_held", bus_b, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_stall_rdy", rdy_b, 0);
      check("t3_stall_done", done_b, 0);
    end
    step(1);
    ack_v[1] = 1'b0;
    wait_done(1, 20, n);
    check("t3_done_latency", n, NS + 1);
    step(1);
    @(negedge clk);
    check("t3_done_one_cycle", done_b, 0);
    check("t3_rdy_after", rdy_b, 1);

    // 4: ack already high at launch
    step(1);
    ack_v[1] = 1'b1;
    step(NS + 1);
    in_data_v[1] = 8'hC3;
    in_valid_v[1] = 1'b1;
    step(1);
    in_valid_v[1] = 1'b0;
    hi_n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (en_b) hi_n++;
      else break;
    end
    check("t4_enable_high_cycles", hi_n, HOLD);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t4_stall_rdy", rdy_b, 0);
      check("t4_stall_done", done_b, 0);
    end
    step(1);
    ack_v[1] = 1'b0;
    wait_done(1, 20, n);
    check("t4_done_latency", n, NS + 1);
    step(2);

    // 5: back-to-back words with in_valid held high
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    cnt0 = done_cnt[0];
    w = 0;
    in_data_v[0] = words[0];
    in_valid_v[0] = 1'b1;
    for (int i = 0; i < 60 && w < 3; i++) begin
      if (rdy_a) begin
        step(1);
        acc[w] = cyc;
        @(negedge clk);
        check($sformatf("t5_bus_word%0d", w), bus_a, words[w]);
        w++;
        if (w < 3) in_data_v[0] = words[w];
        else in_valid_v[0] = 1'b0;
      end else begin
        step(1);
      end
    end
    in_valid_v[0] = 1'b0;
    check("t5_words_accepted", w, 3);
    check("t5_period_01", acc[1] - acc[0], HOLD + GAP + 1);
    check("t5_period_12", acc[2] - acc[1], HOLD + GAP + 1);
    wait_done(0, 20, n);
    step(1);
    check("t5_done_pulses", done_cnt[0] - cnt0, 3);
    step(2);

    // 6: reset in the middle of SEND
    in_data_v[0] = 8'h5A;
    in_data_v[1] = 8'h5A;
    in_valid_v = 2'b11;
    step(1);
    in_valid_v = 2'b00;
    step(1);
    @(negedge clk);
    check("t6_bus_before", bus_b, 8'h5A);
    check("t6_en_before", en_b, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt0 = done_cnt[1];
    step(1);
    @(negedge clk);
    check("t6_en_b", en_b, 0);
    check("t6_bus_b", bus_b, 0);
    check("t6_done_b", done_b, 0);
    check("t6_bus_a", bus_a, 0);
    check("t6_en_a", en_a, 0);
    step(1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rdy_b", rdy_b, 1);
    check("t6_rdy_a", rdy_a, 1);
    step(10);
    check("t6_no_done", done_cnt[1] - cnt0, 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
